// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - packet-granular round-robin arbiter for one FIFO write port
// Define FIFO_WR_ARB_PRIO_EN to give requester 0 strict priority at arbitration time.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] win_id;
  logic                win_found;
  logic                last_xfer;

  // Search starts one past the previous packet owner so every valid requester gets a turn.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
`ifdef FIFO_WR_ARB_PRIO_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
    end
`endif
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_found && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        win_id    = ID_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    busy         = 1'b0;
    last_xfer    = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = BURST;
        end
      end
      BURST: begin
        busy                = 1'b1;
        req_ready[grant_id] = !fifo_full;
        fifo_wr_en          = req_valid[grant_id] & !fifo_full;
        fifo_wr_data        = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        last_xfer           = fifo_wr_en & req_last[grant_id];
        if (last_xfer) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_found) begin
        grant_id <= win_id;
      end
`ifdef FIFO_WR_ARB_PRIO_EN
      // Requester 0 sits outside the rotation, so its packets leave the pointer alone.
      if (last_xfer && grant_id != '0) begin
        rr_ptr <= grant_id;
      end
`else
      if (last_xfer) begin
        rr_ptr <= grant_id;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - directed scoreboard bench for fifo_wr_arb
// Expectations follow FIFO_WR_ARB_PRIO_EN when the bench is built with it defined.
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 32;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_full;
  logic [1:0]       grant_id;
  logic             busy;

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] beat_q[NR][$];
  int          wr_cyc_q[$];
  logic [NR-1:0] en;
  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pkt(input int r, input logic [31:0] base, input int n, input int inc);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      beat_q[r].push_back({(k == n-1) ? 1'b1 : 1'b0, base + 32'(k*inc)});
      e.id   = 2'(r);
      e.data = base + 32'(k*inc);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && beat_q[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = beat_q[i][0][31:0];
        req_last[i]          = beat_q[i][0][32];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [NR-1:0] acc;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (fifo_full) check("no_wr_when_full", {63'd0, fifo_wr_en}, 64'd0);
    acc = req_valid & req_ready;
    if (fifo_wr_en) begin
      wr_cnt++;
      wr_cyc_q.push_back(cyc);
      check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_data", 64'(fifo_wr_data), 64'(e.data));
        check("wr_id", 64'(grant_id), 64'(e.id));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) void'(beat_q[i].pop_front());
    drive();
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int target;
    int k;
    target = wr_cnt + n;
    k = 0;
    while (wr_cnt < target && k < budget) begin
      step();
      k++;
    end
    check(tag, {63'd0, wr_cnt >= target}, 64'd1);
  endtask

  int w0;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    en        = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_wr_en", {63'd0, fifo_wr_en}, 64'd0);
    check("rst_wr_data", 64'(fifo_wr_data), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // all four requesters, 2-beat packets, served 0..3 with one bubble between packets
    for (int i = 0; i < NR; i++) pkt(i, 32'hA0 + 32'(i), 2, 0);
    wr_cyc_q.delete();
    en = 4'b1111;
    drive();
    wait_writes("t1_done", 8, 40);
    check("t1_span", 64'(wr_cyc_q[7] - wr_cyc_q[0]), 64'd10);
    check("t1_bubble", 64'(wr_cyc_q[2] - wr_cyc_q[1]), 64'd2);

    // 5-beat packet from requester 2 stalled by full, requester 1 waiting
    pkt(2, 32'h20, 5, 1);
    en = 4'b0100;
    drive();
    step();
    pkt(1, 32'h11, 1, 1);
    en = 4'b0110;
    drive();
    wait_writes("t2_beat1", 1, 10);
    fifo_full = 1'b1;
    w0 = wr_cnt;
    repeat (3) begin
      step();
      check("t2_busy", {63'd0, busy}, 64'd1);
      check("t2_grant", 64'(grant_id), 64'd2);
    end
    check("t2_stall", 64'(wr_cnt - w0), 64'd0);
    fifo_full = 1'b0;
    wait_writes("t2_done", 5, 30);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // grantee 1 drops valid mid-packet while requester 3 waits
    pkt(1, 32'h30, 4, 1);
    en = 4'b0010;
    drive();
    step();
    pkt(3, 32'h3F, 1, 1);
    en = 4'b1010;
    drive();
    wait_writes("t3_first", 2, 10);
    en[1] = 1'b0;
    drive();
    w0 = wr_cnt;
    repeat (4) begin
      step();
      check("t3_busy", {63'd0, busy}, 64'd1);
      check("t3_grant", 64'(grant_id), 64'd1);
      check("t3_ready3", {63'd0, req_ready[3]}, 64'd0);
    end
    check("t3_hold", 64'(wr_cnt - w0), 64'd0);
    en[1] = 1'b1;
    drive();
    wait_writes("t3_done", 3, 20);

    // reset during beat 2 of a 4-beat packet; pointer must return to its reset value
    pkt(1, 32'h4E, 1, 1);
    en = 4'b0010;
    drive();
    wait_writes("t4_pre", 1, 10);
    pkt(2, 32'h40, 4, 1);
    en = 4'b0100;
    drive();
    wait_writes("t4_beat1", 1, 10);
    #2 rst = 1'b1;
    #1;
    check("t4_async_busy", {63'd0, busy}, 64'd0);
    check("t4_async_wr_en", {63'd0, fifo_wr_en}, 64'd0);
    check("t4_async_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    beat_q[2].delete();
    check("t4_unwritten", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    pkt(0, 32'h50, 1, 1);
    pkt(2, 32'h52, 1, 1);
    en = 4'b0101;
    drive();
    wait_writes("t4_done", 2, 20);

    // requesters 0 and 2 continuously valid with single-beat packets
`ifdef FIFO_WR_ARB_PRIO_EN
    for (int k = 0; k < 3; k++) pkt(0, 32'h60 + 32'(k), 1, 1);
    for (int k = 0; k < 3; k++) pkt(2, 32'h70 + 32'(k), 1, 1);
`else
    for (int k = 0; k < 3; k++) begin
      pkt(0, 32'h60 + 32'(k), 1, 1);
      pkt(2, 32'h70 + 32'(k), 1, 1);
    end
`endif
    en = 4'b0101;
    drive();
    wait_writes("t5_done", 6, 40);

    // single-beat packets from requester 3 over 10 cycles
    for (int k = 0; k < 5; k++) pkt(3, 32'h80 + 32'(k), 1, 1);
    en = 4'b1000;
    drive();
    w0 = wr_cnt;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k > 0) check("t6_grant", 64'(grant_id), 64'd3);
    end
    check("t6_writes", 64'(wr_cnt - w0), 64'd5);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin, packet-granular write-port arbiter that shares one FIFO write port among NUM_REQ requesters.
- Sits entirely in the FIFO write-clock domain, directly in front of the async FIFO write interface (wr_en / wr_data / full).
- A grant is held from the first beat of a packet through its last beat, so packets from different requesters never interleave in the FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, data width of each requester and of the FIFO write port.
- ID_WIDTH, derived localparam = clog2(NUM_REQ), width of grant_id.

Ports:
- clk  in  1  write-domain clock; same clock as the FIFO write side.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed beat data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  marks the final beat of the packet.
- req_ready  out  NUM_REQ  per-requester beat accept.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- grant_id  out  ID_WIDTH  index of the current or most recent grantee.
- busy  out  1  high while in the BURST state.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - state = IDLE; grant_id = 0; rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - Outputs: busy = 0, req_ready = 0, fifo_wr_en = 0, fifo_wr_data = 0.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is set, select the first requester with valid set, searching from rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - Register the winner into grant_id and move to BURST on the next edge.
  - req_ready is all-zero in IDLE. Arbitration latency is 1 cycle from valid to first possible beat.
- BURST:
  - req_ready[grant_id] = !fifo_full. All other ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & !fifo_full, combinational.
  - fifo_wr_data = data of grant_id, combinational; held at the granted data even when fifo_wr_en = 0.
  - A beat transfers when fifo_wr_en = 1.
  - A transfer with req_last[grant_id] = 1 moves the FSM to IDLE and sets rr_ptr = grant_id.
- Throughput and fairness:
  - Beats can transfer back-to-back, one per clock.
  - There is exactly one idle bubble cycle between consecutive packets.
  - No requester wins twice while another requester is continuously valid.
- Boundary conditions:
  - fifo_full asserted mid-packet: no write, grant held, beats stall.
  - fifo_full asserted on the last beat: no transfer, stay in BURST.
  - Grantee drops req_valid mid-packet: grant held indefinitely with no write (no timeout).
  - Non-granted requesters keep their valid high and must not change data while waiting.
  - Single-beat packet (valid and last in the same beat): 1 cycle in BURST, then IDLE.
  - rst asserted mid-packet: immediate return to the reset values. The partial packet already in the FIFO is the FIFO owner's problem, since the FIFO has its own reset.
  - req_last without req_valid is ignored.
- grant_id holds its value in IDLE until the next arbitration win.

Optional Feature:
- Macro: FIFO_WR_ARB_PRIO_EN.
- Defined:
  - Requester 0 is strict priority. In IDLE, if req_valid[0] = 1, requester 0 wins regardless of rr_ptr.
  - The remaining requesters arbitrate round-robin among themselves.
  - rr_ptr updates only on grants to requesters 1..NUM_REQ-1.
  - Requester 0 still cannot pre-empt a packet that is in progress.
- Not defined: pure round-robin over all requesters, as described in Behaviour.

Test Plan:
- Reset, then req_valid=4'b1111, each requester sends a 2-beat packet with data 0xA0+i, fifo_full=0.
  - Required: FIFO sees 0xA0,0xA0,0xA1,0xA1,0xA2,0xA2,0xA3,0xA3.
  - Required: grant_id sequence 0,1,2,3; one bubble cycle between packets.
- Requester 2 sends a 5-beat packet; fifo_full is held high during beats 2-3 for 3 cycles; requester 1 is valid throughout.
  - Required: no fifo_wr_en while full; requester 1 is not granted until after beat 5.
  - Required: FIFO receives all 5 beats in order.
- Requester 1 drops req_valid for 4 cycles mid-packet while requester 3 is valid.
  - Required: busy=1 and grant_id=1 throughout; req_ready[3]=0.
  - Required: packet completes intact, then requester 3 is granted.
- Assert rst for 1 cycle during beat 2 of a 4-beat packet.
  - Required: asynchronously busy=0, fifo_wr_en=0, req_ready=0.
  - Required: the next grant goes to requester 0 when valid.
- With FIFO_WR_ARB_PRIO_EN defined, requesters 0 and 2 are continuously valid with 1-beat packets.
  - Required: grant_id is always 0 while req_valid[0]=1.
  - Required: requester 2 is granted only after req_valid[0] drops. Without the macro, grants alternate 0,2,0,2.
- Single-beat packets from requester 3 only, valid held high for 10 cycles.
  - Required: 5 FIFO writes (BURST/IDLE alternate).
  - Required: grant_id=3 stays constant; fifo_wr_data matches each beat.
